// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants, MDU scoreboard state encoding and helpers for the
// pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_LEN_DEF  = 5;
  localparam int MDU_CNT_LEN       = 8;
  localparam int STALL_CNT_LEN_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // Counter value loaded on launch so that busy spans exactly `latency` cycles.
  function automatic logic [MDU_CNT_LEN-1:0] mdu_cnt_load(input int latency);
    return MDU_CNT_LEN'(latency - 1);
  endfunction

  // A source operand conflicts only when it is actually read and names the writer.
  function automatic logic src_hit(input logic uses, input logic eq);
    return uses & eq;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of pipeline-status inputs and stall/flush/MDU outputs exchanged
// between the pipeline datapath and the hazard/stall controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_FILE_ADDR_LEN = hazard_stall_ctrl_pkg::REG_ADDR_LEN_DEF,
  parameter int STALL_CNT_LEN     = hazard_stall_ctrl_pkg::STALL_CNT_LEN_DEF
);

  logic [REG_FILE_ADDR_LEN-1:0] ID_Rs;
  logic [REG_FILE_ADDR_LEN-1:0] ID_Rt;
  logic                         ID_uses_Rs;
  logic                         ID_uses_Rt;
  logic                         ID_is_mdu;
  logic                         ID_reads_hilo;
  logic [REG_FILE_ADDR_LEN-1:0] EXE_Dest;
  logic                         EXE_MEM_R_EN;
  logic                         EXE_branch_taken;
  logic                         dmem_req;
  logic                         dmem_ready;
  logic                         stat_clr;

  logic                         PC_write_en;
  logic                         IFID_write_en;
  logic                         IFID_flush;
  logic                         IDEX_bubble;
  logic                         pipe_freeze;
  logic                         mdu_start;
  logic                         mdu_busy;
  logic [STALL_CNT_LEN-1:0]     stall_count;

  modport master (
    output ID_Rs, ID_Rt, ID_uses_Rs, ID_uses_Rt, ID_is_mdu, ID_reads_hilo,
           EXE_Dest, EXE_MEM_R_EN, EXE_branch_taken, dmem_req, dmem_ready,
           stat_clr,
    input  PC_write_en, IFID_write_en, IFID_flush, IDEX_bubble, pipe_freeze,
           mdu_start, mdu_busy, stall_count
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_uses_Rs, ID_uses_Rt, ID_is_mdu, ID_reads_hilo,
           EXE_Dest, EXE_MEM_R_EN, EXE_branch_taken, dmem_req, dmem_ready,
           stat_clr,
    output PC_write_en, IFID_write_en, IFID_flush, IDEX_bubble, pipe_freeze,
           mdu_start, mdu_busy, stall_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_mdu_scoreboard.sv
// MDU scoreboard: tracks the multi-cycle MULT/DIV unit. It runs off the raw
// clock and ignores pipe freezes, since the MDU keeps computing regardless.
module hazard_stall_ctrl_mdu_scoreboard
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_busy
);

  mdu_state_e             r_state;
  mdu_state_e             w_state_nxt;
  logic [MDU_CNT_LEN-1:0] r_cnt;
  logic [MDU_CNT_LEN-1:0] w_cnt_nxt;

  // State and countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= {MDU_CNT_LEN{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: launch loads latency-1, busy ends at the edge where the count is zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = mdu_cnt_load(MDU_LATENCY);
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {MDU_CNT_LEN{1'b0}};
        end
      end
      BUSY: begin
        if (r_cnt == {MDU_CNT_LEN{1'b0}}) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {MDU_CNT_LEN{1'b0}};
        end else begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = r_cnt - {{(MDU_CNT_LEN-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {MDU_CNT_LEN{1'b0}};
      end
    endcase
  end

  assign o_busy = (r_state == BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: resolves load-use, MDU structural/HI-LO,
// taken-branch and data-memory wait hazards, and counts stalled cycles.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_FILE_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int MDU_LATENCY       = 32,
  parameter int STALL_CNT_LEN     = STALL_CNT_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [REG_FILE_ADDR_LEN-1:0] ZERO_REG  = {REG_FILE_ADDR_LEN{1'b0}};
  localparam logic [STALL_CNT_LEN-1:0]     STALL_MAX = {STALL_CNT_LEN{1'b1}};
  localparam logic [STALL_CNT_LEN-1:0]     STALL_ONE = {{(STALL_CNT_LEN-1){1'b0}}, 1'b1};

  logic w_lu;
  logic w_mw;
  logic w_sh;
  logic w_mdu_busy;
  logic w_pc_we;
  logic w_ifid_we;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_pipe_freeze;
  logic w_mdu_start;
  logic [STALL_CNT_LEN-1:0] r_stall_count;

  // $zero is never a real dependency, so a load to r0 never stalls
  assign w_lu = bus.EXE_MEM_R_EN & (bus.EXE_Dest != ZERO_REG) &
                (src_hit(bus.ID_uses_Rs, bus.ID_Rs == bus.EXE_Dest) |
                 src_hit(bus.ID_uses_Rt, bus.ID_Rt == bus.EXE_Dest));
  assign w_mw = bus.dmem_req & ~bus.dmem_ready;
  assign w_sh = w_mdu_busy & (bus.ID_is_mdu | bus.ID_reads_hilo);

  // Priority: memory wait > taken branch > load-use / MDU stall > normal issue
  always_comb begin
    w_pc_we       = 1'b1;
    w_ifid_we     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_freeze = 1'b0;
    w_mdu_start   = 1'b0;
    if (!rst_n) begin
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_mw) begin
      w_pipe_freeze = 1'b1;
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
    end else if (bus.EXE_branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_lu | w_sh) begin
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
      w_idex_bubble = 1'b1;
    end else begin
      w_mdu_start   = bus.ID_is_mdu & ~w_mdu_busy;
    end
  end

  hazard_stall_ctrl_mdu_scoreboard #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mdu_start),
    .o_busy  (w_mdu_busy)
  );

  // Saturating stall-cycle counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= {STALL_CNT_LEN{1'b0}};
    end else if (bus.stat_clr) begin
      r_stall_count <= {STALL_CNT_LEN{1'b0}};
    end else if (!w_pc_we && (r_stall_count != STALL_MAX)) begin
      r_stall_count <= r_stall_count + STALL_ONE;
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign bus.PC_write_en   = w_pc_we;
  assign bus.IFID_write_en = w_ifid_we;
  assign bus.IFID_flush    = w_ifid_flush;
  assign bus.IDEX_bubble   = w_idex_bubble;
  assign bus.pipe_freeze   = w_pipe_freeze;
  assign bus.mdu_start     = w_mdu_start;
  assign bus.mdu_busy      = w_mdu_busy;
  assign bus.stall_count   = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random
// traffic, compared every cycle against a behavioural model of the hazard rules.
module tb_hazard_stall_ctrl;

  localparam int LAT  = 4;
  localparam int SCW  = 4;
  localparam int SSAT = 15;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  int   m_left;
  int   m_stall;

  logic g_busy_obs;
  logic g_pc_obs;
  logic g_start_obs;
  logic [SCW-1:0] g_stall_obs;

  hazard_stall_ctrl_if #(.REG_FILE_ADDR_LEN(5), .STALL_CNT_LEN(SCW)) bus ();

  hazard_stall_ctrl #(
    .REG_FILE_ADDR_LEN (5),
    .MDU_LATENCY       (LAT),
    .STALL_CNT_LEN     (SCW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.ID_Rs            = 5'd0;
    bus.ID_Rt            = 5'd0;
    bus.ID_uses_Rs       = 1'b0;
    bus.ID_uses_Rt       = 1'b0;
    bus.ID_is_mdu        = 1'b0;
    bus.ID_reads_hilo    = 1'b0;
    bus.EXE_Dest         = 5'd0;
    bus.EXE_MEM_R_EN     = 1'b0;
    bus.EXE_branch_taken = 1'b0;
    bus.dmem_req         = 1'b0;
    bus.dmem_ready       = 1'b0;
    bus.stat_clr         = 1'b0;
  endtask

  // Entered just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    logic lu, mw, sh, busy;
    logic e_pc, e_ifid, e_flush, e_bub, e_frz, e_start;
    #1;
    busy = (m_left > 0);
    lu = bus.EXE_MEM_R_EN && (bus.EXE_Dest != 5'd0) &&
         ((bus.ID_uses_Rs && bus.ID_Rs == bus.EXE_Dest) ||
          (bus.ID_uses_Rt && bus.ID_Rt == bus.EXE_Dest));
    mw = bus.dmem_req && !bus.dmem_ready;
    sh = busy && (bus.ID_is_mdu || bus.ID_reads_hilo);
    if (mw) begin
      {e_pc, e_ifid, e_flush, e_bub, e_frz, e_start} = 6'b000010;
    end else if (bus.EXE_branch_taken) begin
      {e_pc, e_ifid, e_flush, e_bub, e_frz, e_start} = 6'b111100;
    end else if (lu || sh) begin
      {e_pc, e_ifid, e_flush, e_bub, e_frz, e_start} = 6'b000100;
    end else begin
      {e_pc, e_ifid, e_flush, e_bub, e_frz} = 5'b11000;
      e_start = bus.ID_is_mdu && !busy;
    end
    chk("pc_write_en",   32'(bus.PC_write_en),   32'(e_pc));
    chk("ifid_write_en", 32'(bus.IFID_write_en), 32'(e_ifid));
    chk("ifid_flush",    32'(bus.IFID_flush),    32'(e_flush));
    chk("idex_bubble",   32'(bus.IDEX_bubble),   32'(e_bub));
    chk("pipe_freeze",   32'(bus.pipe_freeze),   32'(e_frz));
    chk("mdu_start",     32'(bus.mdu_start),     32'(e_start));
    chk("mdu_busy",      32'(bus.mdu_busy),      32'(busy));
    chk("stall_count",   32'(bus.stall_count),   32'(m_stall));
    g_busy_obs  = bus.mdu_busy;
    g_pc_obs    = bus.PC_write_en;
    g_start_obs = bus.mdu_start;
    g_stall_obs = bus.stall_count;
    @(posedge clk);
    if (e_start) m_left = LAT;
    else if (m_left > 0) m_left--;
    if (bus.stat_clr) m_stall = 0;
    else if (!e_pc && m_stall < SSAT) m_stall++;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_pc"},     32'(bus.PC_write_en),   32'd0);
    chk({pfx, "_ifid"},   32'(bus.IFID_write_en), 32'd0);
    chk({pfx, "_flush"},  32'(bus.IFID_flush),    32'd1);
    chk({pfx, "_bubble"}, 32'(bus.IDEX_bubble),   32'd1);
    chk({pfx, "_freeze"}, 32'(bus.pipe_freeze),   32'd0);
    chk({pfx, "_start"},  32'(bus.mdu_start),     32'd0);
    chk({pfx, "_busy"},   32'(bus.mdu_busy),      32'd0);
    chk({pfx, "_stall"},  32'(bus.stall_count),   32'd0);
  endtask

  initial begin
    int  nb;
    logic issued;
    n_checks = 0;
    n_errors = 0;
    m_left   = 0;
    m_stall  = 0;
    rst_n    = 1'b0;
    clear_in();
    bus.ID_is_mdu = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    clear_in();
    @(negedge clk);

    // Load-use on Rt=5: one bubble, then the load has moved to MEM
    bus.EXE_MEM_R_EN = 1'b1; bus.EXE_Dest = 5'd5;
    bus.ID_uses_Rt = 1'b1; bus.ID_Rt = 5'd5; bus.ID_Rs = 5'd1; bus.ID_uses_Rs = 1'b1;
    cycle();
    chk("lu_stall_pc", 32'(g_pc_obs), 32'd0);
    bus.EXE_MEM_R_EN = 1'b0;
    cycle();
    chk("lu_release_pc", 32'(g_pc_obs), 32'd1);
    bus.EXE_MEM_R_EN = 1'b1; bus.EXE_Dest = 5'd0; bus.ID_Rt = 5'd0;
    cycle();
    chk("lu_r0_pc", 32'(g_pc_obs), 32'd1);

    // MDU launch then MFHI waits out the busy window
    clear_in();
    bus.ID_is_mdu = 1'b1;
    cycle();
    chk("mdu_launch", 32'(g_start_obs), 32'd1);
    bus.ID_is_mdu = 1'b0; bus.ID_reads_hilo = 1'b1;
    nb = 0; issued = 1'b0;
    for (int i = 0; i < 12 && !issued; i++) begin
      cycle();
      if (g_busy_obs) nb++;
      else issued = 1'b1;
    end
    chk("hilo_issued", 32'(issued), 32'd1);
    chk("mdu_busy_len", 32'(nb), 32'd4);

    // Taken branch beats load-use and squashes an MDU op in ID
    clear_in();
    bus.EXE_branch_taken = 1'b1; bus.EXE_MEM_R_EN = 1'b1; bus.EXE_Dest = 5'd5;
    bus.ID_uses_Rs = 1'b1; bus.ID_Rs = 5'd5; bus.ID_is_mdu = 1'b1;
    cycle();
    chk("br_no_start", 32'(g_start_obs), 32'd0);
    chk("br_pc", 32'(g_pc_obs), 32'd1);

    // Memory wait during MDU busy: freeze does not pause the MDU countdown
    clear_in();
    bus.ID_is_mdu = 1'b1;
    cycle();
    clear_in();
    nb = 0;
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (g_busy_obs) nb++;
    end
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (g_busy_obs) nb++;
    end
    chk("mdu_busy_freeze_len", 32'(nb), 32'd4);

    // Asynchronous reset in the middle of a busy window
    clear_in();
    bus.ID_uses_Rt = 1'b1; bus.ID_Rt = 5'd7; bus.EXE_Dest = 5'd7; bus.EXE_MEM_R_EN = 1'b1;
    cycle();
    clear_in();
    bus.ID_is_mdu = 1'b1;
    cycle();
    clear_in();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    m_left = 0; m_stall = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_reset_busy", 32'(g_busy_obs), 32'd0);

    // Stall counter saturation and clear
    bus.EXE_MEM_R_EN = 1'b1; bus.EXE_Dest = 5'd3; bus.ID_uses_Rs = 1'b1; bus.ID_Rs = 5'd3;
    for (int i = 0; i < 20; i++) cycle();
    clear_in();
    bus.stat_clr = 1'b1;
    cycle();
    chk("stall_saturated", 32'(g_stall_obs), 32'd15);
    bus.stat_clr = 1'b0;
    cycle();
    chk("stall_cleared", 32'(g_stall_obs), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.ID_Rs            = 5'($urandom_range(0, 3));
      bus.ID_Rt            = 5'($urandom_range(0, 3));
      bus.ID_uses_Rs       = 1'($urandom_range(0, 1));
      bus.ID_uses_Rt       = 1'($urandom_range(0, 1));
      bus.ID_is_mdu        = ($urandom_range(0, 5) == 0);
      bus.ID_reads_hilo    = ($urandom_range(0, 3) == 0);
      bus.EXE_Dest         = 5'($urandom_range(0, 3));
      bus.EXE_MEM_R_EN     = ($urandom_range(0, 2) == 0);
      bus.EXE_branch_taken = ($urandom_range(0, 7) == 0);
      bus.dmem_req         = ($urandom_range(0, 3) == 0);
      bus.dmem_ready       = 1'($urandom_range(0, 1));
      bus.stat_clr         = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It works alongside the EXE-stage forwarding unit and covers the hazards forwarding cannot resolve:
- load-use data hazards
- multi-cycle MULT/DIV (MDU) structural and HI/LO hazards
- taken-branch flushes
- data-memory wait states
Outputs drive the PC and IF/ID write enables, the ID/EX bubble mux, the global pipe freeze and MDU start. A saturating stall-cycle performance counter is included.

Parameters:
REG_FILE_ADDR_LEN, 5, register-file address width (from defines.v)
MDU_LATENCY, 32, cycles the MDU is busy after start (2..255)
STALL_CNT_LEN, 16, width of the stall performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ID_Rs  in  REG_FILE_ADDR_LEN  Rs of the instruction in ID
ID_Rt  in  REG_FILE_ADDR_LEN  Rt of the instruction in ID
ID_uses_Rs  in  1  ID instruction reads Rs
ID_uses_Rt  in  1  ID instruction reads Rt
ID_is_mdu  in  1  ID instruction is MULT/MULTU/DIV/DIVU
ID_reads_hilo  in  1  ID instruction is MFHI/MFLO
EXE_Dest  in  REG_FILE_ADDR_LEN  destination register of the EXE instruction
EXE_MEM_R_EN  in  1  EXE instruction is a load
EXE_branch_taken  in  1  branch resolved taken in EXE
dmem_req  in  1  MEM stage is accessing data memory
dmem_ready  in  1  data memory completes this cycle
stat_clr  in  1  synchronous clear of stall_count
PC_write_en  out  1  PC update enable
IFID_write_en  out  1  IF/ID register enable
IFID_flush  out  1  IF/ID register is loaded with a NOP
IDEX_bubble  out  1  ID/EX register is loaded with a NOP
pipe_freeze  out  1  holds all pipe registers, PC and the register-file write
mdu_start  out  1  one-cycle MDU launch pulse
mdu_busy  out  1  MDU is computing
stall_count  out  STALL_CNT_LEN  saturating count of cycles with PC_write_en=0

Behaviour:
Reset:
- Reset is asynchronous, active-low, single clock clk.
- While rst_n=0: PC_write_en=0, IFID_write_en=0, IFID_flush=1, IDEX_bubble=1, pipe_freeze=0, mdu_start=0, mdu_busy=0, stall_count=0, MDU counter=0.
- Reset mid-MDU aborts the operation. mdu_busy=0 on the first cycle after release.

Hazard terms (combinational, same cycle):
- lu = EXE_MEM_R_EN & EXE_Dest!=0 & ((ID_uses_Rs & ID_Rs==EXE_Dest) | (ID_uses_Rt & ID_Rt==EXE_Dest))
- mw = dmem_req & ~dmem_ready
- sh = mdu_busy & (ID_is_mdu | ID_reads_hilo)

Priority (highest first), combinational outputs:
1. mw: pipe_freeze=1, PC_write_en=0, IFID_write_en=0, IDEX_bubble=0, IFID_flush=0. No bubble is inserted.
2. EXE_branch_taken: PC_write_en=1, IFID_write_en=1, IFID_flush=1, IDEX_bubble=1. This overrides lu and sh. A squashed ID MDU op does not start.
3. lu | sh: PC_write_en=0, IFID_write_en=0, IDEX_bubble=1.
4. Otherwise: PC_write_en=1, IFID_write_en=1, all others 0.

Load-use:
- Exactly one bubble per load-use pair. The next cycle the load is in MEM and forwarding resolves the dependence.

MDU scoreboard (registered), states IDLE and BUSY:
- mdu_start=1 when ID_is_mdu & ~mdu_busy & no higher-priority condition (issue cycle).
- IDLE->BUSY on mdu_start; counter loads MDU_LATENCY-1.
- In BUSY the counter decrements every cycle, including during pipe_freeze (the MDU is independent of the pipe).
- BUSY->IDLE when counter==0 at a clock edge. mdu_busy is registered and equals (state==BUSY).
- The instruction stalled by sh issues on the first cycle mdu_busy=0.

stall_count:
- Increments on each cycle with PC_write_en=0 while rst_n=1.
- Saturates at all-ones.
- stat_clr has priority over increment and sets 0 at the next edge.

Decomposition:
- defines.v gains MDU_CNT_LEN (8), STALL_CNT_LEN and the MDU state encodings IDLE=1'b0, BUSY=1'b1. REG_FILE_ADDR_LEN is reused.
- One sub-module, mdu_scoreboard: it holds the counter and state, takes start, and outputs busy.
- Priority logic and stall_count stay in hazard_stall_ctrl.

Test Plan:
- Load with EXE_Dest=5, ID uses Rt=5 -> one cycle PC_write_en=0, IDEX_bubble=1; same with EXE_Dest=0 -> no stall.
- ID_is_mdu, MDU_LATENCY=4 -> mdu_start pulse one cycle, then mdu_busy=1 for exactly 4 cycles. MFHI in ID during that window stalls until mdu_busy=0.
- EXE_branch_taken with a simultaneous load-use hit and ID_is_mdu -> IFID_flush=1, IDEX_bubble=1, PC_write_en=1, mdu_start=0.
- dmem_req=1, dmem_ready=0 for 3 cycles during MDU busy -> pipe_freeze=1 for 3 cycles, IDEX_bubble=0, MDU counter keeps decrementing.
- rst_n low mid-BUSY (asynchronous, between edges) -> mdu_busy=0 immediately and after release; stall_count=0.
- STALL_CNT_LEN=4 with 20 stall cycles -> stall_count stops at 15; stat_clr -> 0 next edge.
